// File: rtl/insn_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package insn_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] START_PC_DEFAULT = 32'h8002_0000;
    localparam logic [1:0]  ACCESS_WORD      = 2'b10;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/insn_fetch_pc_gen.sv
// Program counter register with redirect / sequential / hold next-PC selection.
module insn_fetch_pc_gen
    import insn_fetch_pkg::*;
#(
    parameter logic [31:0] START_PC = START_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    // Redirect wins over sequential advance; otherwise the PC holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= START_PC;
        end else if (load) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: FSM, fetch/decode output registers and delivered-count.
// Optional INSN_FETCH_ALIGN_CHECK_EN halts on a misaligned redirect target.
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter logic [31:0] START_PC = START_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    output logic [31:0] insn_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         misaligned;
    logic         hold;
    logic         take_redirect;
    logic         advance;

    assign target = redirect_pc & 32'hFFFF_FFFC;

`ifdef INSN_FETCH_ALIGN_CHECK_EN
    assign misaligned = |redirect_pc[1:0];
`else
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        hold          = stall && valid_out;
        take_redirect = redirect && (state != HALT) && !misaligned;
        advance       = (state == RUN) && !redirect && !hold && fetch_en;
    end

    insn_fetch_pc_gen #(
        .START_PC (START_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (take_redirect),
        .advance (advance),
        .target  (target),
        .pc      (pc)
    );

    assign mem_address     = pc;
    assign mem_data_in     = '0;
    assign mem_write       = 1'b0;
    assign mem_access_size = ACCESS_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            insn_out    <= '0;
            pc_out      <= '0;
            valid_out   <= 1'b0;
            fetch_count <= '0;
`ifdef INSN_FETCH_ALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                HALT: valid_out <= 1'b0;
                default: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        if (misaligned) begin
                            state <= HALT;
`ifdef INSN_FETCH_ALIGN_CHECK_EN
                            misalign_err <= 1'b1;
`endif
                        end else if (state == IDLE && fetch_en) begin
                            state <= RUN;
                        end
                    end else if (state == IDLE) begin
                        if (fetch_en) state <= RUN;
                    end else if (hold) begin
                        // Decode has not taken the current word; keep presenting it.
                    end else if (!fetch_en) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        insn_out    <= mem_data_out;
                        pc_out      <= pc;
                        valid_out   <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: directed vector table, hand sequences, random vs. model.
module tb_insn_fetch;

    localparam logic [31:0] START = 32'h8002_0000;
`ifdef INSN_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_write;
    logic [1:0]  mem_access_size;
    logic [31:0] insn_out, pc_out, fetch_count;
    logic        valid_out, misalign_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h8002_0000: memf = 32'h9876_5432;
            32'h8002_0004: memf = 32'h1111_1111;
            32'h8002_0008: memf = 32'h2222_2222;
            32'h8002_000C: memf = 32'h3333_3333;
            default:       memf = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign mem_data_out = memf(mem_address);

    insn_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_write       (mem_write),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out),
        .insn_out        (insn_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out),
        .fetch_count     (fetch_count),
        .misalign_err    (misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"},  {31'd0, valid_out}, 32'd0);
        chk({tag, ".pc_out"}, pc_out, 32'd0);
        chk({tag, ".insn"},   insn_out, 32'd0);
        chk({tag, ".count"},  fetch_count, 32'd0);
        chk({tag, ".mis"},    {31'd0, misalign_err}, 32'd0);
        chk({tag, ".addr"},   mem_address, START);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fe, st, rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ecnt;
        logic        emis;
    } vec_t;

    function automatic vec_t mk(input logic fe, input logic st, input logic rd, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc, input logic [31:0] ecnt,
                                input logic emis);
        mk = '{fe, st, rd, rpc, ev, epc, ecnt, emis};
    endfunction

    vec_t tbl[24];

    // Reference model: one call per clock edge, applied from the behavioural rules.
    logic        m_run, m_halt, m_valid, m_mis;
    logic [31:0] m_pc, m_pc_out, m_insn, m_cnt;

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_valid = 0; m_mis = 0;
        m_pc = START; m_pc_out = 0; m_insn = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic fe, input logic st, input logic rd, input logic [31:0] rpc);
        if (m_halt) begin
            m_valid = 0;
        end else if (rd) begin
            m_valid = 0;
            if (ALIGN && rpc[1:0] != 2'b00) begin
                m_mis = 1; m_halt = 1;
            end else begin
                m_pc = {rpc[31:2], 2'b00};
                if (fe) m_run = 1;
            end
        end else if (!m_run) begin
            if (fe) m_run = 1;
        end else if (st && m_valid) begin
            // output held
        end else if (!fe) begin
            m_valid = 0; m_run = 0;
        end else begin
            m_insn = memf(m_pc); m_pc_out = m_pc; m_valid = 1;
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,            0, 0,            0, 0);
        tbl[1]  = mk(1,0,0,0,            1, 32'h80020000, 1, 0);
        tbl[2]  = mk(1,0,0,0,            1, 32'h80020004, 2, 0);
        tbl[3]  = mk(1,1,0,0,            1, 32'h80020004, 2, 0);
        tbl[4]  = mk(1,1,0,0,            1, 32'h80020004, 2, 0);
        tbl[5]  = mk(1,1,0,0,            1, 32'h80020004, 2, 0);
        tbl[6]  = mk(1,0,0,0,            1, 32'h80020008, 3, 0);
        tbl[7]  = mk(1,0,0,0,            1, 32'h8002000C, 4, 0);
        tbl[8]  = mk(1,1,1,32'h80020100, 0, 0,            4, 0);
        tbl[9]  = mk(1,0,0,0,            1, 32'h80020100, 5, 0);
        tbl[10] = mk(1,0,1,32'hFFFFFFFC, 0, 0,            5, 0);
        tbl[11] = mk(1,0,0,0,            1, 32'hFFFFFFFC, 6, 0);
        tbl[12] = mk(1,0,0,0,            1, 32'h00000000, 7, 0);
        tbl[13] = mk(0,0,0,0,            0, 0,            7, 0);
        tbl[14] = mk(0,0,0,0,            0, 0,            7, 0);
        tbl[15] = mk(1,0,0,0,            0, 0,            7, 0);
        tbl[16] = mk(1,0,0,0,            1, 32'h00000004, 8, 0);
        tbl[17] = mk(0,1,0,0,            1, 32'h00000004, 8, 0);
        tbl[18] = mk(0,0,0,0,            0, 0,            8, 0);
        tbl[19] = mk(1,0,0,0,            0, 0,            8, 0);
        tbl[20] = mk(1,0,0,0,            1, 32'h00000008, 9, 0);
        if (ALIGN) begin
            tbl[21] = mk(1,0,1,32'h80020102, 0, 0, 9, 1);
            tbl[22] = mk(1,0,0,0,            0, 0, 9, 1);
            tbl[23] = mk(1,0,0,0,            0, 0, 9, 1);
        end else begin
            tbl[21] = mk(1,0,1,32'h80020102, 0, 0,            9,  0);
            tbl[22] = mk(1,0,0,0,            1, 32'h80020100, 10, 0);
            tbl[23] = mk(1,0,0,0,            1, 32'h80020104, 11, 0);
        end

        do_reset();
        chk_reset_outputs("reset");
        chk("const.wr",   {31'd0, mem_write}, 32'd0);
        chk("const.din",  mem_data_in, 32'd0);
        chk("const.size", {30'd0, mem_access_size}, 32'd2);

        for (int i = 0; i < 24; i++) begin
            fetch_en = tbl[i].fe; stall = tbl[i].st;
            redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
            step();
            chk($sformatf("row%0d.valid", i), {31'd0, valid_out}, {31'd0, tbl[i].ev});
            chk($sformatf("row%0d.count", i), fetch_count, tbl[i].ecnt);
            chk($sformatf("row%0d.mis", i), {31'd0, misalign_err}, {31'd0, tbl[i].emis});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d.pc", i), pc_out, tbl[i].epc);
                chk($sformatf("row%0d.insn", i), insn_out, memf(tbl[i].epc));
            end
        end

        // Reset clears a halted or running stage; then a stall on a bubble is ignored.
        do_reset();
        chk_reset_outputs("rst2");
        fetch_en = 1; step();
        stall = 1; step();
        chk("bubble.valid", {31'd0, valid_out}, 32'd1);
        chk("bubble.pc", pc_out, START);
        stall = 0; step();
        chk("bubble.pc2", pc_out, START + 32'd4);

        // Asynchronous reset between edges takes effect before the next edge.
        #2;
        rst_n = 0;
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        rst_n = 1;

        // Random phase against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] r;
            logic fe, st, rd;
            logic [31:0] rpc;
            if (m_halt && ($urandom % 4 == 0)) begin
                do_reset();
                model_reset();
                chk_reset_outputs("rnd.rst");
            end
            r   = $urandom;
            fe  = (r[2:0] != 3'd0);
            st  = (r[4:3] == 2'd0);
            rd  = (r[8:5] == 4'd0);
            rpc = $urandom;
            if (r[12:9] != 4'd0) rpc[1:0] = 2'b00;
            if (r[13]) rpc[31:16] = 16'h8002;
            fetch_en = fe; stall = st; redirect = rd; redirect_pc = rpc;
            model_edge(fe, st, rd, rpc);
            step();
            chk("rnd.valid", {31'd0, valid_out}, {31'd0, m_valid});
            chk("rnd.count", fetch_count, m_cnt);
            chk("rnd.mis",   {31'd0, misalign_err}, {31'd0, m_mis});
            chk("rnd.addr",  mem_address, m_pc);
            if (m_valid) begin
                chk("rnd.pc",   pc_out, m_pc_out);
                chk("rnd.insn", insn_out, m_insn);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
